// File: rtl/ball_render_if.sv
// Scan-side bundle for ball_render: ball position in, raster timing and ball mask out.
interface ball_render_if;
  logic        pix_en;
  logic [9:0]  x_ball;
  logic [15:0] y_ball;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        ball_on;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        frame_tick;
  logic [15:0] cam_y;

  modport master (
    output pix_en, x_ball, y_ball,
    input  hsync, vsync, video_on, ball_on, hcount, vcount, frame_tick, cam_y
  );

  modport slave (
    input  pix_en, x_ball, y_ball,
    output hsync, vsync, video_on, ball_on, hcount, vcount, frame_tick, cam_y
  );
endinterface

// File: rtl/ball_render.sv
// 640x480 raster scan (800x525 total) with a camera-following square ball overlay.
// Every output is registered together with the counters it describes; pix_en only paces the scan, nothing stalls.
module ball_render #(
  parameter int BALL_R     = 8,
  parameter int CAM_MARGIN = 320
) (
  input  logic         clk,
  input  logic         reset,
  ball_render_if.slave bus
);
  localparam logic [9:0]  H_ACTIVE   = 10'd640;
  localparam logic [9:0]  H_SYNC_BEG = 10'd656;
  localparam logic [9:0]  H_SYNC_END = 10'd751;
  localparam logic [9:0]  H_LAST     = 10'd799;
  localparam logic [9:0]  V_ACTIVE   = 10'd480;
  localparam logic [9:0]  V_SYNC_BEG = 10'd490;
  localparam logic [9:0]  V_SYNC_END = 10'd491;
  localparam logic [9:0]  V_LAST     = 10'd524;
  localparam logic [15:0] CAM_MAX    = 16'd65056;
  localparam logic [16:0] MARGIN17   = 17'(CAM_MARGIN);
  localparam logic [15:0] MARGIN16   = 16'(CAM_MARGIN);
  localparam logic signed [11:0] R12      = 12'(BALL_R);
  localparam logic signed [18:0] R19      = 19'(BALL_R);
  localparam logic signed [18:0] ROW_LAST = 19'sd479;

  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        ball_on;
  logic        frame_tick;
  logic [15:0] cam_y;
  logic [9:0]  x_lat;
  logic [15:0] y_lat;

  logic [9:0]  h_next;
  logic [9:0]  v_next;
  logic        vid_next;
  logic        tick_next;
  logic [15:0] cam_cand;
  logic [15:0] cam_next;
  logic signed [16:0] dy;
  logic signed [18:0] rc;
  logic signed [18:0] vs;
  logic signed [11:0] hs;
  logic signed [11:0] xs;
  logic        col_hit;
  logic        row_hit;

  always_comb begin
    h_next = hcount + 10'd1;
    v_next = vcount;
    if (hcount == H_LAST) begin
      h_next = '0;
      v_next = (vcount == V_LAST) ? '0 : vcount + 10'd1;
    end
  end

  assign vid_next  = (h_next < H_ACTIVE) && (v_next < V_ACTIVE);
  assign tick_next = (h_next == '0) && (v_next == V_ACTIVE);

  // Compare in 17 bits so a camera near the top of the world never wraps.
  always_comb begin
    cam_cand = bus.y_ball - MARGIN16;
    cam_next = cam_y;
    if ({1'b0, bus.y_ball} > ({1'b0, cam_y} + MARGIN17))
      cam_next = (cam_cand > CAM_MAX) ? CAM_MAX : cam_cand;
  end

  assign dy = $signed({1'b0, y_lat}) - $signed({1'b0, cam_y});
  assign rc = ROW_LAST - {{2{dy[16]}}, dy};
  assign vs = $signed({9'b0, v_next});
  assign hs = $signed({2'b0, h_next});
  assign xs = $signed({2'b0, x_lat});

  assign col_hit = (hs >= xs - R12) && (hs <= xs + R12);
  assign row_hit = (vs >= rc - R19) && (vs <= rc + R19);

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount     <= '0;
      vcount     <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
      ball_on    <= 1'b0;
      frame_tick <= 1'b0;
      cam_y      <= '0;
      x_lat      <= '0;
      y_lat      <= '0;
    end else begin
      // The tick is a single clk pulse even when pix_en is sparse.
      frame_tick <= 1'b0;
      if (bus.pix_en) begin
        hcount     <= h_next;
        vcount     <= v_next;
        hsync      <= !((h_next >= H_SYNC_BEG) && (h_next <= H_SYNC_END));
        vsync      <= !((v_next >= V_SYNC_BEG) && (v_next <= V_SYNC_END));
        video_on   <= vid_next;
        ball_on    <= vid_next && col_hit && row_hit;
        frame_tick <= tick_next;
        if (tick_next) begin
          x_lat <= bus.x_ball;
          y_lat <= bus.y_ball;
          cam_y <= cam_next;
        end
      end
    end
  end

  assign bus.hcount     = hcount;
  assign bus.vcount     = vcount;
  assign bus.hsync      = hsync;
  assign bus.vsync      = vsync;
  assign bus.video_on   = video_on;
  assign bus.ball_on    = ball_on;
  assign bus.frame_tick = frame_tick;
  assign bus.cam_y      = cam_y;
endmodule

// File: tb/tb_ball_render.sv
// Directed frames for ball_render; per-frame statistics are scored against queued expectations at each frame_tick.
module tb_ball_render;
  logic clk;
  logic rst;
  int   pe_div;
  int   checks;
  int   errors;

  typedef struct {
    int gap;
    int nball;
    int hmin;
    int hmax;
    int vmin;
    int vmax;
    int vs_low;
    int cam;
  } exp_t;

  exp_t sbq[$];

  ball_render_if bus ();

  ball_render #(.BALL_R(8), .CAM_MARGIN(320)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    checks = 0;
    errors = 0;
    pe_div = 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic push(input int gap, input int nball, input int hmin, input int hmax,
                      input int vmin, input int vmax, input int vs_low, input int cam);
    exp_t e;
    e.gap = gap; e.nball = nball; e.hmin = hmin; e.hmax = hmax;
    e.vmin = vmin; e.vmax = vmax; e.vs_low = vs_low; e.cam = cam;
    sbq.push_back(e);
  endtask

  initial begin : pe_drive
    int cnt;
    cnt = 0;
    bus.pix_en = 1'b0;
    forever begin
      @(negedge clk);
      cnt++;
      bus.pix_en = (pe_div == 1) || (cnt % pe_div == 0);
    end
  end

  logic pe_s;
  logic rst_s;
  always @(posedge clk) begin
    pe_s  <= bus.pix_en;
    rst_s <= rst;
  end

  initial begin : monitor
    int gap, nball, hmin, hmax, vmin, vmax, hs_low, hs_bad, vs_low, blank_ball;
    exp_t e;
    gap = 0; nball = 0; hmin = 9999; hmax = -1; vmin = 9999; vmax = -1;
    hs_low = 0; hs_bad = 0; vs_low = 0; blank_ball = 0;
    forever begin
      @(negedge clk);
      if (rst_s === 1'b1) begin
        gap = 0; nball = 0; hmin = 9999; hmax = -1; vmin = 9999; vmax = -1;
        hs_low = 0; hs_bad = 0; vs_low = 0; blank_ball = 0;
      end else if (pe_s === 1'b1) begin
        gap++;
        if (bus.ball_on === 1'b1) begin
          nball++;
          if (int'(bus.hcount) < hmin) hmin = int'(bus.hcount);
          if (int'(bus.hcount) > hmax) hmax = int'(bus.hcount);
          if (int'(bus.vcount) < vmin) vmin = int'(bus.vcount);
          if (int'(bus.vcount) > vmax) vmax = int'(bus.vcount);
          if (bus.video_on !== 1'b1) blank_ball++;
        end
        if (bus.hsync === 1'b0) hs_low++;
        if (bus.vsync === 1'b0) vs_low++;
        if (bus.hcount == 10'd799) begin
          if (hs_low != 96) hs_bad++;
          hs_low = 0;
        end
        if (bus.frame_tick === 1'b1) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tick: tick at gap %0d with nothing queued", gap);
          end else begin
            e = sbq.pop_front();
            chk("tick_gap", gap, e.gap);
            chk("ball_pixels", nball, e.nball);
            chk("ball_hmin", hmin, e.hmin);
            chk("ball_hmax", hmax, e.hmax);
            chk("ball_vmin", vmin, e.vmin);
            chk("ball_vmax", vmax, e.vmax);
            chk("vsync_low", vs_low, e.vs_low);
            chk("hsync_bad_lines", hs_bad, 0);
            chk("ball_in_blank", blank_ball, 0);
            chk("cam_y", bus.cam_y, e.cam);
            chk("tick_hcount", bus.hcount, 0);
            chk("tick_vcount", bus.vcount, 480);
          end
          gap = 0; nball = 0; hmin = 9999; hmax = -1; vmin = 9999; vmax = -1;
          hs_bad = 0; vs_low = 0; blank_ball = 0;
        end
      end
    end
  end

  initial begin : tick_width
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) w++;
      else if (w != 0) begin
        chk("tick_width", w, 1);
        w = 0;
      end
    end
  end

  task automatic wait_tick(input string name);
    for (int i = 0; i < 2000000; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) return;
    end
    abort(name);
  endtask

  task automatic wait_pos(input int h, input int v);
    for (int i = 0; i < 300000; i++) begin
      @(negedge clk);
      if (int'(bus.hcount) == h && int'(bus.vcount) == v) return;
    end
    abort("wait_pos");
  endtask

  task automatic do_reset(input int cycles);
    logic p;
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    chk("rst_hcount", bus.hcount, 0);
    chk("rst_vcount", bus.vcount, 0);
    chk("rst_hsync", bus.hsync, 1);
    chk("rst_vsync", bus.vsync, 1);
    chk("rst_video_on", bus.video_on, 0);
    chk("rst_ball_on", bus.ball_on, 0);
    chk("rst_frame_tick", bus.frame_tick, 0);
    chk("rst_cam_y", bus.cam_y, 0);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      p = bus.pix_en;
      @(negedge clk);
      if (p) break;
    end
    chk("first_hcount", bus.hcount, 1);
    chk("first_vcount", bus.vcount, 0);
    chk("first_video_on", bus.video_on, 1);
  endtask

  initial begin : stim
    rst = 1'b1;
    bus.x_ball = 10'd320;
    bus.y_ball = 16'd100;
    do_reset(3);

    push(384000, 81, 0, 8, 471, 479, 0, 0);
    wait_tick("tick1");
    bus.x_ball = 10'd3;
    bus.y_ball = 16'd500;
    pe_div = 4;

    push(420000, 289, 312, 328, 371, 387, 1600, 180);
    wait_tick("tick2");
    bus.x_ball = 10'd639;
    bus.y_ball = 16'd400;
    pe_div = 1;

    push(420000, 204, 0, 11, 151, 167, 1600, 180);
    wait_tick("tick3");
    bus.x_ball = 10'd320;
    bus.y_ball = 16'hFFFF;

    push(420000, 153, 631, 639, 251, 267, 1600, 65056);
    wait_tick("tick4");
    bus.y_ball = 16'd100;

    wait_pos(300, 200);
    do_reset(1);
    push(384000, 81, 0, 8, 471, 479, 0, 0);
    wait_tick("tick5");

    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ball_render.md
BALL_RENDER -- requirements
Module: ball_render

Interface
REQ-001 Parameter BALL_R, default 8: ball half-size in pixels; the ball is drawn as a (2*BALL_R+1)-pixel square.
REQ-002 Parameter CAM_MARGIN, default 320: screen distance, in rows above the bottom row, at which the camera starts to follow the ball.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 pix_en  input  1  pixel-rate enable; counters and outputs advance only on cycles where pix_en=1.
REQ-006 x_ball  input  10  ball centre column, screen coordinates, 0..639.
REQ-007 y_ball  input  16  ball centre height, world coordinates, increasing upward.
REQ-008 hsync  output  1  horizontal sync, active-low.
REQ-009 vsync  output  1  vertical sync, active-low.
REQ-010 video_on  output  1  current pixel lies in the 640x480 active area.
REQ-011 ball_on  output  1  current pixel lies inside the ball square.
REQ-012 hcount  output  10  current pixel column counter, 0..799.
REQ-013 vcount  output  10  current line counter, 0..524.
REQ-014 frame_tick  output  1  one-cycle pulse marking the start of vertical blank.
REQ-015 cam_y  output  16  world height shown on screen row 479 (the bottom row).

Function
REQ-016 On every pix_en cycle, hcount increments; after 799 it wraps to 0 and vcount increments; after vcount=524 with hcount=799, vcount wraps to 0.
REQ-017 Cycles with pix_en=0 hold every register and output unchanged.
REQ-018 Timing: horizontal 640 active / 16 front porch / 96 sync / 48 back porch; vertical 480 / 10 / 2 / 33.
REQ-019 Sync pulses: hsync=0 iff hcount is in 656..751; vsync=0 iff vcount is in 490..491.
REQ-020 video_on=1 iff hcount<640 and vcount<480.
REQ-021 All outputs are registered and describe the hcount/vcount values present in the same cycle, with zero skew between them.
REQ-022 frame_tick=1 for exactly one clk cycle: the pix_en cycle in which the counters become (hcount=0, vcount=480).
REQ-023 On that same cycle, x_ball and y_ball are captured into x_lat and y_lat, and cam_y is updated; these values stay constant for the whole following frame.
REQ-024 Camera update: if y_ball > cam_y + CAM_MARGIN, then cam_y <= y_ball - CAM_MARGIN; otherwise cam_y holds. The camera never moves downward.
REQ-025 cam_y saturates at 65056 (65535-479); the addition cam_y + CAM_MARGIN is computed in 17 bits and never wraps.
REQ-026 dy = y_lat - cam_y, computed as a 17-bit signed value; screen centre row rc = 479 - dy, signed.
REQ-027 Ball columns: hcount in [x_lat-BALL_R, x_lat+BALL_R], evaluated with 12-bit signed arithmetic so there is no wrap near column 0 or column 639.
REQ-028 Ball rows: vcount in [rc-BALL_R, rc+BALL_R], signed; a ball wholly off-screen (rc < -BALL_R or rc > 479+BALL_R) produces no ball_on.
REQ-029 ball_on = video_on AND column match AND row match; it is never asserted during blanking.
REQ-030 Changes on x_ball/y_ball between frame ticks have no effect on the current frame.

Reset
REQ-031 While reset=1 at a clk edge, regardless of pix_en: hcount=0, vcount=0, hsync=1, vsync=1, video_on=0, ball_on=0, frame_tick=0, cam_y=0, x_lat=0, y_lat=0.
REQ-032 On the first pix_en cycle after reset deasserts, the counters advance to (1,0) and video_on=1.
REQ-033 A reset asserted mid-frame abandons the frame, and scanning restarts at (0,0).

Verification
REQ-034 pix_en high every 4th clk; run 2 frames -> hsync low exactly 96 pix_en cycles per line, vsync low exactly 2 lines per frame, 420000 pix_en cycles between frame_ticks.
REQ-035 x_ball=320, y_ball=100, cam_y=0 after reset -> ball_on exactly for hcount 312..328 and vcount 371..387 (289 pixels per frame).
REQ-036 x_ball=3 -> ball_on columns 0..11 only, with no wrap to columns near 799; x_ball=639 -> columns 631..639.
REQ-037 y_ball steps 100 -> 500 -> 400 across successive frame ticks -> cam_y 0 -> 180 -> 180.
REQ-038 y_ball=65535 -> cam_y=65056, with no 16-bit overflow.
REQ-039 reset pulsed at (hcount=300, vcount=200) -> next cycle shows all reset values; the following frame_tick occurs after exactly 384000 pix_en cycles; changing y_ball mid-frame leaves ball_on rows unchanged until the next tick.
